// File: rtl/cpu_boot_ctrl.sv
// Boot/run/dump sequencer beside the RISC-V cpu: streams IMEM/DMEM images in, runs the cpu, streams DMEM out.
// Define CPU_BOOT_CTRL_CHECKSUM_EN to add dump_csum, the mod-2^64 sum of all dumped words.

module cpu_boot_ctrl #(
   parameter int unsigned IMEM_WORDS = 512,
   parameter int unsigned DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [9:0]  imem_len,
   input  logic [10:0] dmem_len,
   input  logic [31:0] run_cycles,
   input  logic [10:0] dump_len,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        cpu_enable,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   input  logic [63:0] rdata_ext_2,
   output logic        busy,
   output logic        done
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
   ,
   output logic [63:0] dump_csum
`endif
);

   localparam int unsigned LEN_W = 11;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_I   = 3'd1;
   localparam logic [2:0] S_LOAD_D   = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_DUMP_RD  = 3'd4;
   localparam logic [2:0] S_DUMP_WT  = 3'd5;
   localparam logic [2:0] S_DUMP_OUT = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   logic [2:0]       state, state_d;
   logic [LEN_W-1:0] cnt, cnt_d, cnt_inc;
   logic [LEN_W-1:0] imem_len_q, imem_len_d, dmem_len_q, dmem_len_d, dump_len_q, dump_len_d;
   logic [31:0]      run_cnt, run_cnt_d;
   logic             hs_in;

   logic             cpu_enable_d, wen_ext_d, wen_ext_2_d, ren_ext_2_d, out_valid_d, busy_d, done_d;
   logic [63:0]      addr_ext_d, addr_ext_2_d, wdata_ext_2_d, out_data_d;
   logic [31:0]      wdata_ext_d;
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
   logic [63:0]      csum_d;
`else
   // no checksum accumulator in this build
`endif

   function automatic logic [LEN_W-1:0] clamp(input logic [LEN_W-1:0] len, input logic [LEN_W-1:0] lim);
      return (len > lim) ? lim : len;
   endfunction

   // Zero-length loads never offer ready, so no word is accepted before the state exits.
   assign in_ready = ((state == S_LOAD_I) && (imem_len_q != '0)) ||
                     ((state == S_LOAD_D) && (dmem_len_q != '0));
   assign hs_in    = in_valid && in_ready;
   assign cnt_inc  = cnt + LEN_W'(1);
   assign ren_ext  = 1'b0;

   // Next state plus next value of every registered output.
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      imem_len_d    = imem_len_q;
      dmem_len_d    = dmem_len_q;
      dump_len_d    = dump_len_q;
      run_cnt_d     = run_cnt;
      cpu_enable_d  = 1'b0;
      wen_ext_d     = 1'b0;
      addr_ext_d    = '0;
      wdata_ext_d   = '0;
      wen_ext_2_d   = 1'b0;
      ren_ext_2_d   = 1'b0;
      addr_ext_2_d  = '0;
      wdata_ext_2_d = '0;
      out_valid_d   = 1'b0;
      out_data_d    = out_data;
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
      csum_d        = dump_csum;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               imem_len_d = clamp(LEN_W'(imem_len), LEN_W'(IMEM_WORDS));
               dmem_len_d = clamp(dmem_len, LEN_W'(DMEM_WORDS));
               dump_len_d = clamp(dump_len, LEN_W'(DMEM_WORDS));
               run_cnt_d  = run_cycles;
               cnt_d      = '0;
               state_d    = S_LOAD_I;
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         S_LOAD_I: begin
            if (imem_len_q == '0) begin
               state_d = S_LOAD_D;
            end else if (hs_in) begin
               wen_ext_d   = 1'b1;
               addr_ext_d  = 64'({cnt, 2'b00});
               wdata_ext_d = in_data[31:0];
               if (cnt_inc == imem_len_q) begin
                  cnt_d   = '0;
                  state_d = S_LOAD_D;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_LOAD_D: begin
            if (dmem_len_q == '0) begin
               state_d = S_RUN;
            end else if (hs_in) begin
               wen_ext_2_d   = 1'b1;
               addr_ext_2_d  = 64'({cnt, 3'b000});
               wdata_ext_2_d = in_data;
               if (cnt_inc == dmem_len_q) begin
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_RUN: begin
            // First RUN cycle carries the final DMEM write; enable follows one cycle later.
            if (run_cnt != '0) begin
               cpu_enable_d = 1'b1;
               run_cnt_d    = run_cnt - 32'd1;
            end else begin
               cnt_d   = '0;
               state_d = (dump_len_q == '0) ? S_DONE : S_DUMP_RD;
            end
         end
         S_DUMP_RD: state_d = S_DUMP_WT;
         S_DUMP_WT: begin
            out_data_d  = rdata_ext_2;
            out_valid_d = 1'b1;
            state_d     = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            out_valid_d = 1'b1;
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = cnt_inc;
               state_d     = (cnt_inc < dump_len_q) ? S_DUMP_RD : S_DONE;
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
               csum_d      = dump_csum + out_data;
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_DUMP_RD) begin
         ren_ext_2_d  = 1'b1;
         addr_ext_2_d = 64'({cnt_d, 3'b000});
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         imem_len_q  <= '0;
         dmem_len_q  <= '0;
         dump_len_q  <= '0;
         run_cnt     <= '0;
         cpu_enable  <= 1'b0;
         wen_ext     <= 1'b0;
         addr_ext    <= '0;
         wdata_ext   <= '0;
         wen_ext_2   <= 1'b0;
         ren_ext_2   <= 1'b0;
         addr_ext_2  <= '0;
         wdata_ext_2 <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
         dump_csum   <= '0;
`endif
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         imem_len_q  <= imem_len_d;
         dmem_len_q  <= dmem_len_d;
         dump_len_q  <= dump_len_d;
         run_cnt     <= run_cnt_d;
         cpu_enable  <= cpu_enable_d;
         wen_ext     <= wen_ext_d;
         addr_ext    <= addr_ext_d;
         wdata_ext   <= wdata_ext_d;
         wen_ext_2   <= wen_ext_2_d;
         ren_ext_2   <= ren_ext_2_d;
         addr_ext_2  <= addr_ext_2_d;
         wdata_ext_2 <= wdata_ext_2_d;
         out_valid   <= out_valid_d;
         out_data    <= out_data_d;
         busy        <= busy_d;
         done        <= done_d;
`ifdef CPU_BOOT_CTRL_CHECKSUM_EN
         dump_csum   <= csum_d;
`endif
      end
   end

endmodule
